memory_access: RTL and testbench

//  Memory stage of the 5-stage RV64 pipeline: takes the executed instruction, runs its load/store over dbus,
//  and presents memory_data_t to the writeback stage. Owns the dbus FSM; stalls the pipe while a transaction is in flight.
//  Non-memory instructions pass through in zero cycles.

---
 rtl/memory_access_pkg.sv | 94 +++++++++
 rtl/memory_access_load.sv | 26 ++
 rtl/memory_access.sv | 143 ++++++++++++++
 tb/tb_memory_access.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: bus bundles, stage bundles, FSM states.
// Helpers: strobe_of (byte-lane mask), isMisaligned (used with MEM_MISALIGN_EN).
package memory_access_pkg;

    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    localparam logic [5:0] CAUSE_LOAD_MISALIGN  = 6'd4;
    localparam logic [5:0] CAUSE_STORE_MISALIGN = 6'd6;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_DONE
    } mem_state_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic            error;
        logic [5:0]      cause;
        logic [XLEN-1:0] mtval;
    } csr_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     raw_instr;
        logic [XLEN-1:0] aluout;
        logic            memread;
        logic            memwrite;
        msize_t          msize;
        logic            memsign;
        logic [XLEN-1:0] wdata;
        logic [4:0]      dst;
        logic            regwrite;
        logic            memtoreg;
        csr_t            csr;
        logic            skip;
    } execute_data_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     raw_instr;
        logic [XLEN-1:0] aluout;
        logic [XLEN-1:0] readdata;
        logic [4:0]      dst;
        logic            regwrite;
        logic            memtoreg;
        csr_t            csr;
        logic            skip;
    } memory_data_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [XLEN-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [XLEN-1:0] data;
    } dbus_resp_t;

    function automatic logic [STRB_W-1:0] strobe_of(msize_t sz, logic [2:0] off);
        logic [STRB_W-1:0] mask;
        unique case (sz)
            MSIZE1:  mask = 8'h01;
            MSIZE2:  mask = 8'h03;
            MSIZE4:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

    function automatic logic isMisaligned(msize_t sz, logic [2:0] off);
        unique case (sz)
            MSIZE1:  return 1'b0;
            MSIZE2:  return off[0];
            MSIZE4:  return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load.sv
// load_extend: picks the addressed bytes out of a 64-bit bus word and
// sign/zero-extends them. Ports: data, offset (addr[2:0]), msize, memsign -> readdata.
module load_extend
    import memory_access_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  msize_t          msize,
    input  logic            memsign,
    output logic [XLEN-1:0] readdata
);

    logic [XLEN-1:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        unique case (msize)
            MSIZE1:  readdata = {{56{memsign & shifted[7]}}, shifted[7:0]};
            MSIZE2:  readdata = {{48{memsign & shifted[15]}}, shifted[15:0]};
            MSIZE4:  readdata = {{32{memsign & shifted[31]}}, shifted[31:0]};
            default: readdata = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage; issues loads/stores on dbus, stalls while waiting.
// Ports: clk, reset, dataE, flush, freeze, dreq, dresp, dataM, stallM. Option: MEM_MISALIGN_EN.
module memory_access
    import memory_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          flush,
    input  logic          freeze,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          stallM
);

    mem_state_t      state;
    dbus_req_t       reqQ;
    logic [XLEN-1:0] capQ;
    logic            killQ;

    dbus_req_t       reqNew;
    logic            memAcc;
    logic            misalign;
    logic            memop;
    logic            kill;
    logic [XLEN-1:0] rawData;
    logic [XLEN-1:0] loadData;
    logic            unusedBus;

    assign unusedBus = dresp.addr_ok;
    assign memAcc = dataE.valid & (dataE.memread | dataE.memwrite);

`ifdef MEM_MISALIGN_EN
    assign misalign = memAcc & isMisaligned(dataE.msize, dataE.aluout[2:0]);
`else
    assign misalign = 1'b0;
`endif

    assign memop = memAcc & ~misalign;

    always_comb begin
        reqNew       = '0;
        reqNew.valid = 1'b1;
        reqNew.addr  = dataE.aluout;
        reqNew.size  = dataE.msize;
        if (dataE.memwrite) begin
            reqNew.strobe = strobe_of(dataE.msize, dataE.aluout[2:0]);
            reqNew.data   = dataE.wdata << {dataE.aluout[2:0], 3'b000};
        end
    end

    // WAIT drives the latched request so the bus sees it stable
    // even if the killed instruction's dataE changes underneath.
    always_comb begin
        dreq    = '0;
        stallM  = 1'b0;
        kill    = flush;
        rawData = dresp.data;
        unique case (state)
            MS_IDLE: begin
                if (memop && !flush) begin
                    dreq   = reqNew;
                    stallM = ~dresp.data_ok;
                end
            end
            MS_WAIT: begin
                dreq   = reqQ;
                stallM = ~dresp.data_ok;
                kill   = flush | killQ;
            end
            default: rawData = capQ;
        endcase
        if (reset) begin
            dreq   = '0;
            stallM = 1'b0;
        end
    end

    load_extend uLoad (
        .data     (rawData),
        .offset   (dataE.aluout[2:0]),
        .msize    (dataE.msize),
        .memsign  (dataE.memsign),
        .readdata (loadData)
    );

    always_comb begin
        dataM.valid     = dataE.valid & ~stallM & ~kill & ~reset;
        dataM.pc        = dataE.pc;
        dataM.raw_instr = dataE.raw_instr;
        dataM.aluout    = dataE.aluout;
        dataM.readdata  = loadData;
        dataM.dst       = dataE.dst;
        dataM.regwrite  = dataE.regwrite;
        dataM.memtoreg  = dataE.memtoreg;
        dataM.csr       = dataE.csr;
        dataM.skip      = dataE.skip;
        if (misalign) begin
            dataM.csr.error = 1'b1;
            dataM.csr.cause = dataE.memwrite ? CAUSE_STORE_MISALIGN
                                             : CAUSE_LOAD_MISALIGN;
            dataM.csr.mtval = dataE.aluout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MS_IDLE;
            reqQ  <= '0;
            capQ  <= '0;
            killQ <= 1'b0;
        end else begin
            unique case (state)
                MS_IDLE: begin
                    if (memop && !flush) begin
                        if (dresp.data_ok) begin
                            capQ <= dresp.data;
                            if (freeze) state <= MS_DONE;
                        end else begin
                            reqQ  <= reqNew;
                            killQ <= 1'b0;
                            state <= MS_WAIT;
                        end
                    end
                end
                MS_WAIT: begin
                    if (flush) killQ <= 1'b1;
                    if (dresp.data_ok) begin
                        capQ  <= dresp.data;
                        killQ <= 1'b0;
                        state <= (freeze && !flush && !killQ) ? MS_DONE : MS_IDLE;
                    end
                end
                MS_DONE: begin
                    if (flush || !freeze) state <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: vector table for single-cycle
// accesses plus sequences for wait, freeze, flush and reset corners.
module tb_memory_access;
    import memory_access_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          flush;
    logic          freeze;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          stallM;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_access dut (
        .clk    (clk),
        .reset  (reset),
        .dataE  (dataE),
        .flush  (flush),
        .freeze (freeze),
        .dreq   (dreq),
        .dresp  (dresp),
        .dataM  (dataM),
        .stallM (stallM)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        msize_t      sz;
        logic        sgn;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] bus;
        logic        expReq;
        logic [7:0]  expStrb;
        logic [63:0] expData;
        logic [63:0] expRd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic execute_data_t mkE(input logic rd, input logic wr, input msize_t sz,
                                          input logic sgn, input logic [63:0] addr,
                                          input logic [63:0] wdata);
        execute_data_t e;
        e           = '0;
        e.valid     = 1'b1;
        e.pc        = 64'h8000_1000;
        e.raw_instr = 32'h0000_0013;
        e.aluout    = addr;
        e.memread   = rd;
        e.memwrite  = wr;
        e.msize     = sz;
        e.memsign   = sgn;
        e.wdata     = wdata;
        e.dst       = 5'd7;
        e.regwrite  = rd;
        e.memtoreg  = rd;
        return e;
    endfunction

    task automatic bus(input logic ok, input logic [63:0] d);
        dresp.addr_ok = 1'b1;
        dresp.data_ok = ok;
        dresp.data    = d;
    endtask

    int accesses;

    initial begin
        vecs[0]  = '{0, 0, MSIZE8, 0, 64'h1234, 64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h0};
        vecs[1]  = '{1, 0, MSIZE1, 1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
                     1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{1, 0, MSIZE1, 0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
                     1, 8'h00, 64'h0, 64'h80};
        vecs[3]  = '{0, 1, MSIZE2, 0, 64'h8000_0006, 64'hBEEF, 64'h0,
                     1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0};
        vecs[4]  = '{1, 0, MSIZE4, 1, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000,
                     1, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321};
        vecs[5]  = '{1, 0, MSIZE2, 0, 64'h8000_0002, 64'h0, 64'h0000_0000_ABCD_0000,
                     1, 8'h00, 64'h0, 64'hABCD};
        vecs[6]  = '{0, 1, MSIZE1, 0, 64'h8000_0005, 64'h5A, 64'h0,
                     1, 8'h20, 64'h0000_5A00_0000_0000, 64'h0};
        vecs[7]  = '{0, 1, MSIZE8, 0, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0,
                     1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[8]  = '{1, 0, MSIZE8, 0, 64'h8000_0010, 64'h0, 64'hFEDC_BA98_7654_3210,
                     1, 8'h00, 64'h0, 64'hFEDC_BA98_7654_3210};
        vecs[9]  = '{1, 0, MSIZE2, 1, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000,
                     1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
        vecs[10] = '{1, 0, MSIZE4, 0, 64'h8000_0000, 64'h0, 64'h0000_0000_F000_0001,
                     1, 8'h00, 64'h0, 64'hF000_0001};

        // reset state, with a load presented and the bus answering
        reset  = 1'b1;
        flush  = 1'b0;
        freeze = 1'b0;
        dataE  = mkE(1, 0, MSIZE8, 0, 64'h8000_0008, 0);
        bus(1, 64'h55);
        @(negedge clk);
        #1;
        chk("reset_dreq_valid", 64'(dreq.valid), 64'd0);
        chk("reset_stall", 64'(stallM), 64'd0);
        chk("reset_dataM_valid", 64'(dataM.valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // single-cycle accesses (data_ok same cycle)
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            dataE = mkE(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sgn,
                        vecs[i].addr, vecs[i].wdata);
            bus(1, vecs[i].bus);
            #1;
            chk($sformatf("v%0d_dreq_valid", i), 64'(dreq.valid), 64'(vecs[i].expReq));
            chk($sformatf("v%0d_stall", i), 64'(stallM), 64'd0);
            chk($sformatf("v%0d_dataM_valid", i), 64'(dataM.valid), 64'd1);
            chk($sformatf("v%0d_strobe", i), 64'(dreq.strobe), 64'(vecs[i].expStrb));
            if (vecs[i].expReq) chk($sformatf("v%0d_addr", i), dreq.addr, vecs[i].addr);
            if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), dreq.data, vecs[i].expData);
            if (vecs[i].rd) chk($sformatf("v%0d_readdata", i), dataM.readdata, vecs[i].expRd);
        end
        chk("pc_copy", dataM.pc, 64'h8000_1000);

        // LD with data_ok after 3 stall cycles
        @(negedge clk);
        dataE = mkE(1, 0, MSIZE8, 0, 64'h8000_0008, 0);
        bus(0, 64'hDEAD);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("ld_wait%0d_stall", c), 64'(stallM), 64'd1);
            chk($sformatf("ld_wait%0d_valid", c), 64'(dataM.valid), 64'd0);
            chk($sformatf("ld_wait%0d_addr", c), dreq.addr, 64'h8000_0008);
            @(negedge clk);
        end
        bus(1, 64'h1122_3344_5566_7788);
        #1;
        chk("ld_done_stall", 64'(stallM), 64'd0);
        chk("ld_done_valid", 64'(dataM.valid), 64'd1);
        chk("ld_done_readdata", dataM.readdata, 64'h1122_3344_5566_7788);

        // SH held stable across 2 wait cycles
        @(negedge clk);
        dataE = mkE(0, 1, MSIZE2, 0, 64'h8000_0006, 64'hBEEF);
        bus(0, 64'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("sh_w%0d_valid", c), 64'(dreq.valid), 64'd1);
            chk($sformatf("sh_w%0d_strobe", c), 64'(dreq.strobe), 64'hC0);
            chk($sformatf("sh_w%0d_data", c), dreq.data, 64'hBEEF_0000_0000_0000);
            chk($sformatf("sh_w%0d_stall", c), 64'(stallM), 64'(c < 2));
            @(negedge clk);
            if (c == 1) bus(1, 64'h0);
        end
        bus(0, 64'h0);

        // data_ok under freeze: held in DONE for 2 cycles, one bus access
        dataE  = mkE(1, 0, MSIZE4, 1, 64'h8000_0004, 0);
        freeze = 1'b1;
        bus(1, 64'h8765_4321_0000_0000);
        accesses = 0;
        #1;
        accesses += int'(dreq.valid);
        chk("frz0_readdata", dataM.readdata, 64'hFFFF_FFFF_8765_4321);
        chk("frz0_stall", 64'(stallM), 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus(c == 0, 64'h0BAD_0BAD_0BAD_0BAD);
            #1;
            accesses += int'(dreq.valid);
            chk($sformatf("frz%0d_dreq_valid", c + 1), 64'(dreq.valid), 64'd0);
            chk($sformatf("frz%0d_readdata", c + 1), dataM.readdata, 64'hFFFF_FFFF_8765_4321);
            chk($sformatf("frz%0d_stall", c + 1), 64'(stallM), 64'd0);
        end
        @(negedge clk);
        freeze = 1'b0;
        bus(0, 64'h0);
        #1;
        accesses += int'(dreq.valid);
        chk("frz_release_readdata", dataM.readdata, 64'hFFFF_FFFF_8765_4321);
        chk("frz_accesses", 64'(accesses), 64'd1);
        @(negedge clk);
        dataE = mkE(0, 0, MSIZE8, 0, 64'h40, 0);
        #1;
        chk("frz_after_dreq", 64'(dreq.valid), 64'd0);

        // flush while waiting; data_ok 2 cycles later
        @(negedge clk);
        dataE = mkE(1, 0, MSIZE8, 0, 64'h8000_0018, 0);
        bus(0, 64'h0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_w0_dreq", 64'(dreq.valid), 64'd1);
        chk("fl_w0_stall", 64'(stallM), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_w1_dreq", 64'(dreq.valid), 64'd1);
        chk("fl_w1_addr", dreq.addr, 64'h8000_0018);
        chk("fl_w1_stall", 64'(stallM), 64'd1);
        @(negedge clk);
        bus(1, 64'h77);
        #1;
        chk("fl_ok_dreq", 64'(dreq.valid), 64'd1);
        chk("fl_ok_stall", 64'(stallM), 64'd0);
        chk("fl_ok_dataM_valid", 64'(dataM.valid), 64'd0);
        @(negedge clk);
        bus(0, 64'h0);
        dataE = mkE(0, 0, MSIZE8, 0, 64'h99, 0);
        #1;
        chk("fl_add_dreq", 64'(dreq.valid), 64'd0);
        chk("fl_add_valid", 64'(dataM.valid), 64'd1);
        chk("fl_add_stall", 64'(stallM), 64'd0);

        // flush in IDLE: no request
        @(negedge clk);
        dataE = mkE(1, 0, MSIZE8, 0, 64'h8000_0020, 0);
        flush = 1'b1;
        #1;
        chk("fl_idle_dreq", 64'(dreq.valid), 64'd0);
        chk("fl_idle_stall", 64'(stallM), 64'd0);
        chk("fl_idle_valid", 64'(dataM.valid), 64'd0);

        // data_ok coinciding with flush in WAIT
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        bus(1, 64'h33);
        #1;
        chk("flok_stall", 64'(stallM), 64'd0);
        chk("flok_valid", 64'(dataM.valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        bus(0, 64'h0);
        dataE = mkE(0, 0, MSIZE8, 0, 64'h5, 0);
        #1;
        chk("flok_next_dreq", 64'(dreq.valid), 64'd0);
        chk("flok_next_valid", 64'(dataM.valid), 64'd1);

        // reset mid-transaction
        @(negedge clk);
        dataE = mkE(1, 0, MSIZE8, 0, 64'h8000_0028, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_dreq", 64'(dreq.valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dataE = mkE(0, 0, MSIZE8, 0, 64'h6, 0);
        #1;
        chk("rst_after_dreq", 64'(dreq.valid), 64'd0);
        chk("rst_after_stall", 64'(stallM), 64'd0);
        chk("rst_after_valid", 64'(dataM.valid), 64'd1);

        // misaligned LW
        @(negedge clk);
        dataE = mkE(1, 0, MSIZE4, 1, 64'h8000_0002, 0);
        bus(0, 64'h0);
        #1;
`ifdef MEM_MISALIGN_EN
        chk("mis_dreq", 64'(dreq.valid), 64'd0);
        chk("mis_stall", 64'(stallM), 64'd0);
        chk("mis_valid", 64'(dataM.valid), 64'd1);
        chk("mis_error", 64'(dataM.csr.error), 64'd1);
        chk("mis_cause", 64'(dataM.csr.cause), 64'd4);
        chk("mis_mtval", dataM.csr.mtval, 64'h8000_0002);
`else
        chk("mis_dreq", 64'(dreq.valid), 64'd1);
        chk("mis_addr", dreq.addr, 64'h8000_0002);
        chk("mis_error", 64'(dataM.csr.error), 64'd0);
        @(negedge clk);
        bus(1, 64'h0);
        #1;
        chk("mis_done_stall", 64'(stallM), 64'd0);
`endif
        @(negedge clk);
        bus(0, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
